dot_product: RTL and testbench



---
 rtl/dot_product_pkg.sv | 21 ++
 rtl/fxp_mul.sv | 14 +
 rtl/dot_product.sv | 85 ++++++++
 tb/tb_dot_product.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Width and saturation helpers shared by the dot_product datapath.
package dot_product_pkg;

   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   // Extra clog2(n) bits let n full-width products be summed without overflow.
   function automatic int acc_width(input int w, input int n);
      return 2 * w + $clog2(n);
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/fxp_mul.sv
// One signed full-width multiplier lane: W x W -> 2W bits, no truncation.
module fxp_mul
   import dot_product_pkg::*;
#(
   parameter int W = 32
) (
   input  logic signed [W-1:0]             a_i,
   input  logic signed [W-1:0]             b_i,
   output logic signed [prod_width(W)-1:0] p_o
);

   assign p_o = a_i * b_i;

endmodule

// File: rtl/dot_product.sv
// Registered signed fixed-point dot product with floor rescaling.
// Define DOT_PRODUCT_SATURATE_EN to clamp instead of wrap on overflow.
module dot_product
   import dot_product_pkg::*;
#(
   parameter int ELEMENT_WIDTH    = 32,
   parameter int DECIMAL_PLACE    = 8,
   parameter int VECTOR_DIMENSION = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic signed [ELEMENT_WIDTH-1:0] vec0 [0:VECTOR_DIMENSION-1],
   input  logic signed [ELEMENT_WIDTH-1:0] vec1 [0:VECTOR_DIMENSION-1],
   output logic signed [ELEMENT_WIDTH-1:0] product
);

   localparam int W      = ELEMENT_WIDTH;
   localparam int N      = VECTOR_DIMENSION;
   localparam int PROD_W = prod_width(W);
   localparam int ACC_W  = acc_width(W, N);
   localparam int LVLS   = $clog2(N);
   localparam int LEAVES = 1 << LVLS;

   logic signed [PROD_W-1:0] prod   [0:LEAVES-1];
   logic signed [ACC_W-1:0]  tree   [0:LEAVES-1];
   logic signed [ACC_W-1:0]  shifted;
   logic signed [W-1:0]      product_d;
   logic signed [W-1:0]      product_q;

   // Pad the lane count to a power of two so the tree is balanced.
   for (genvar i = 0; i < LEAVES; i++) begin : g_lane
      if (i < N) begin : g_mul
         fxp_mul #(.W(W)) u_mul (
            .a_i (vec0[i]),
            .b_i (vec1[i]),
            .p_o (prod[i])
         );
      end else begin : g_pad
         assign prod[i] = '0;
      end
   end

   // In-place pairwise reduction; node j of a level reads nodes 2j, 2j+1
   // of the previous level, which are never overwritten before use.
   always_comb begin
      for (int i = 0; i < LEAVES; i++) begin
         tree[i] = ACC_W'(prod[i]);
      end
      for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
         for (int j = 0; j < w; j++) begin
            tree[j] = tree[2*j] + tree[2*j+1];
         end
      end
   end

   // Arithmetic shift of the exact sum gives floor rounding, applied once.
   assign shifted = tree[0] >>> DECIMAL_PLACE;

`ifdef DOT_PRODUCT_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(W));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(W));

   always_comb begin
      product_d = shifted[W-1:0];
      if (shifted > SAT_MAX) begin
         product_d = SAT_MAX[W-1:0];
      end else if (shifted < SAT_MIN) begin
         product_d = SAT_MIN[W-1:0];
      end
   end
`else
   assign product_d = shifted[W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         product_q <= '0;
      end else begin
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_dot_product.sv
// Bench for dot_product: directed table, reset sequences, random vs model.
module tb_dot_product;

   localparam int W  = 32;
   localparam int DP = 8;
   localparam int N  = 3;

   typedef struct packed {
      logic [N-1:0][W-1:0] a;
      logic [N-1:0][W-1:0] b;
      logic [W-1:0]        exp_wrap;
      logic [W-1:0]        exp_sat;
   } vec_t;

   logic                clk;
   logic                reset;
   logic signed [W-1:0] v0 [0:N-1];
   logic signed [W-1:0] v1 [0:N-1];
   logic signed [W-1:0] product;

   int total = 0;
   int bad   = 0;

   dot_product #(
      .ELEMENT_WIDTH    (W),
      .DECIMAL_PLACE    (DP),
      .VECTOR_DIMENSION (N)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .vec0    (v0),
      .vec1    (v1),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b);
      for (int i = 0; i < N; i++) begin
         v0[i] = a[i];
         v1[i] = b[i];
      end
   endtask

   // Mathematical reference: exact integer sum, floor divide by 2^DP,
   // then either modulo 2^W or clamp to the signed W-bit range.
   function automatic logic [W-1:0] model(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b);
      logic signed [127:0] acc;
      logic signed [127:0] q;
      logic signed [127:0] lo;
      logic signed [127:0] hi;
      acc = 0;
      for (int i = 0; i < N; i++) begin
         acc = acc + 128'(longint'($signed(a[i])) * longint'($signed(b[i])));
      end
      q = acc / 256;
      if (acc < 0 && (acc % 256) != 0) q = q - 1;
`ifdef DOT_PRODUCT_SATURATE_EN
      hi = 128'(32'sh7FFF_FFFF);
      lo = -128'sd2147483648;
      if (q > hi) q = hi;
      if (q < lo) q = lo;
`else
      lo = 0;
      hi = 0;
`endif
      return q[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd_elem();
      logic [W-1:0] r;
      r = $urandom;
      case ($urandom_range(0, 2))
         0:       return r;
         1:       return {{16{r[15]}}, r[15:0]};
         default: return {{24{r[7]}}, r[7:0]};
      endcase
   endfunction

   vec_t tbl [7];
   logic [N-1:0][W-1:0] ra, rb, za;
   logic [W-1:0] want;

   initial begin
      tbl[0] = '{a: {32'h694D, 32'hABC0, 32'h1080}, b: {32'h3416, 32'hDFF8, 32'hDD00},
                 exp_wrap: 32'h00B9EDD2, exp_sat: 32'h00B9EDD2};
      tbl[1] = '{a: {32'h694D, 32'hABC0, 32'hFFFFEF80}, b: {32'h3416, 32'hDFF8, 32'hDD00},
                 exp_wrap: 32'h009D70D2, exp_sat: 32'h009D70D2};
      tbl[2] = '{a: {32'h0, 32'h0, 32'hFFFFFFFF}, b: {32'h0, 32'h0, 32'h80},
                 exp_wrap: 32'hFFFFFFFF, exp_sat: 32'hFFFFFFFF};
      tbl[3] = '{a: {32'h0, 32'h0, 32'h7FFFFFFF}, b: {32'h0, 32'h0, 32'h7FFFFFFF},
                 exp_wrap: 32'hFF000000, exp_sat: 32'h7FFFFFFF};
      tbl[4] = '{a: {32'h0, 32'h0, 32'h80000000}, b: {32'h0, 32'h0, 32'h7FFFFFFF},
                 exp_wrap: 32'h00800000, exp_sat: 32'h80000000};
      tbl[5] = '{a: {32'h0, 32'h0, 32'h0}, b: {32'h0, 32'h0, 32'h0},
                 exp_wrap: 32'h0, exp_sat: 32'h0};
      // 1.0*1.0 + 2.0*3.0 + (-1.0)*0.5 = 6.5
      tbl[6] = '{a: {32'hFFFFFF00, 32'h200, 32'h100}, b: {32'h80, 32'h300, 32'h100},
                 exp_wrap: 32'h680, exp_sat: 32'h680};

      // Reset held with nonzero inputs.
      reset = 1'b1;
      apply(tbl[0].a, tbl[0].b);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("reset_hold", product, '0);
      end

      // Inputs change together with reset deassertion; back-to-back vectors.
      reset = 1'b0;
      for (int k = 0; k < 7; k++) begin
         apply(tbl[k].a, tbl[k].b);
`ifdef DOT_PRODUCT_SATURATE_EN
         want = tbl[k].exp_sat;
`else
         want = tbl[k].exp_wrap;
`endif
         @(posedge clk); #1;
         check($sformatf("table%0d", k), product, want);
      end

      // Mid-stream reset discards the in-flight result.
      apply(tbl[0].a, tbl[0].b);
      @(posedge clk); #1;
      check("pre_reset", product, 32'h00B9EDD2);
      reset = 1'b1;
      apply(tbl[1].a, tbl[1].b);
      @(posedge clk); #1;
      check("mid_reset", product, '0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_reset", product, 32'h009D70D2);

      // Output holds when inputs do not change between edges.
      @(posedge clk); #1;
      check("hold", product, 32'h009D70D2);

      // Randomized stream, one result per cycle.
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < N; i++) begin
            ra[i] = rnd_elem();
            rb[i] = rnd_elem();
         end
         apply(ra, rb);
         want = model(ra, rb);
         @(posedge clk); #1;
         check("random", product, want);
      end

      // Reset after random traffic, then a zero vector.
      reset = 1'b1;
      @(posedge clk); #1;
      check("final_reset", product, '0);
      reset = 1'b0;
      za = '0;
      apply(za, ra);
      @(posedge clk); #1;
      check("zero_vec", product, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
